// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets
// (relative to MMIO_BASE) and console status bit positions.
package data_mem_responder_pkg;

  localparam logic [31:0] OFF_GPIO     = 32'h0000_0000;
  localparam logic [31:0] OFF_CYCLE_LO = 32'h0000_0004;
  localparam logic [31:0] OFF_CYCLE_HI = 32'h0000_0008;
  localparam logic [31:0] OFF_CON_STAT = 32'h0000_000C;
  localparam logic [31:0] OFF_CON_TX   = 32'h0000_0010;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;

endpackage

// File: rtl/data_mem_responder_console_fifo.sv
// Synchronous byte FIFO feeding the console transmitter. No fall-through:
// a push into an empty FIFO becomes visible at the head on the next cycle.
module console_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // When full, a simultaneous pop frees the head slot, which is exactly wr_ptr.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/data_mem_responder.sv
// M-stage data-memory responder: word RAM plus MMIO window holding GPIO,
// a free-running 64-bit cycle counter and the console TX FIFO.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic [31:0] gpio_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]       ram_q [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_hit;
  logic [31:0]       mmio_off, word_off;
  logic              mmio_hit;
  logic              sel_gpio, sel_clo, sel_chi, sel_stat, sel_tx;
  logic [31:0]       gpio_q, gpio_d;
  logic [63:0]       cycle_q, cycle_d;
  logic              ovf_q, ovf_d;
  logic              fifo_full, fifo_empty, fifo_pop, push_req;
  logic              unused_addr_bits;

  assign ram_hit  = (ALUResultM < RAM_BYTES);
  assign ram_idx  = ALUResultM[RAM_AW+1:2];
  assign mmio_off = ALUResultM - MMIO_BASE;
  assign word_off = {mmio_off[31:2], 2'b00};
  assign mmio_hit = !ram_hit;
  assign sel_gpio = mmio_hit && (word_off == OFF_GPIO);
  assign sel_clo  = mmio_hit && (word_off == OFF_CYCLE_LO);
  assign sel_chi  = mmio_hit && (word_off == OFF_CYCLE_HI);
  assign sel_stat = mmio_hit && (word_off == OFF_CON_STAT);
  assign sel_tx   = mmio_hit && (word_off == OFF_CON_TX);
  assign unused_addr_bits = ^mmio_off[1:0];

  assign push_req = MemWriteM && sel_tx;
  assign tx_valid = !fifo_empty;
  assign fifo_pop = tx_valid && tx_ready;
  assign gpio_out = gpio_q;

  console_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .rst_ni  (reset),
    .push_i  (push_req),
    .pop_i   (fifo_pop),
    .data_i  (WriteDataM[7:0]),
    .head_o  (tx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    gpio_d  = gpio_q;
    cycle_d = cycle_q + 64'd1;
    ovf_d   = ovf_q;
    if (MemWriteM && sel_gpio) gpio_d = WriteDataM;
    if (MemWriteM && sel_stat && WriteDataM[STAT_OVF_BIT]) ovf_d = 1'b0;
    // A dropped push in the same cycle as a clear keeps the flag set.
    if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q  <= '0;
      cycle_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      gpio_q  <= gpio_d;
      cycle_q <= cycle_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (MemWriteM && ram_hit) ram_q[ram_idx] <= WriteDataM;
  end

  always_comb begin
    ReadDataM = '0;
    if (ram_hit) begin
      ReadDataM = ram_q[ram_idx];
    end else if (sel_gpio) begin
      ReadDataM = gpio_q;
    end else if (sel_clo) begin
      ReadDataM = cycle_q[31:0];
    end else if (sel_chi) begin
      ReadDataM = cycle_q[63:32];
    end else if (sel_stat) begin
      ReadDataM[STAT_FULL_BIT]  = fifo_full;
      ReadDataM[STAT_EMPTY_BIT] = fifo_empty;
      ReadDataM[STAT_OVF_BIT]   = ovf_q;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM, GPIO, cycle counter,
// console FIFO full/overflow/drain and asynchronous reset behaviour.
module tb_data_mem_responder;

  localparam logic [31:0] MMIO     = 32'h1000_0000;
  localparam logic [31:0] A_GPIO   = MMIO + 32'h00;
  localparam logic [31:0] A_CLO    = MMIO + 32'h04;
  localparam logic [31:0] A_CHI    = MMIO + 32'h08;
  localparam logic [31:0] A_STAT   = MMIO + 32'h0C;
  localparam logic [31:0] A_TX     = MMIO + 32'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic [31:0] gpio_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int vectors = 0;
  int miscompares = 0;

  data_mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .gpio_out   (gpio_out),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ALUResultM = a;
    WriteDataM = d;
    MemWriteM  = 1'b1;
    tick();
    MemWriteM  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    ALUResultM = a;
    #1;
    d = ReadDataM;
  endtask

  initial begin
    logic [31:0] r, c1, c2;
    reset      = 1'b0;
    MemWriteM  = 1'b0;
    ALUResultM = '0;
    WriteDataM = '0;
    tx_ready   = 1'b0;
    #2;
    chk("rst_gpio", gpio_out, 32'h0);
    chk("rst_txvalid", {31'b0, tx_valid}, 32'h0);
    chk("rst_txdata", {24'b0, tx_data}, 32'h0);
    rd(A_CLO, r);
    chk("rst_cyclo", r, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Step 1: RAM write then read, byte-offset ignored, same-cycle ordering
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, r);
    chk("ram_rd_10", r, 32'hDEAD_BEEF);
    rd(32'h13, r);
    chk("ram_rd_13", r, 32'hDEAD_BEEF);
    wr(32'h20, 32'h1111_1111);
    ALUResultM = 32'h20;
    WriteDataM = 32'h2222_2222;
    MemWriteM  = 1'b1;
    #1;
    chk("ram_same_cycle_old", ReadDataM, 32'h1111_1111);
    tick();
    MemWriteM = 1'b0;
    rd(32'h20, r);
    chk("ram_after_write", r, 32'h2222_2222);
    wr(32'hFC, 32'hCAFE_F00D);
    rd(32'hFC, r);
    chk("ram_last_word", r, 32'hCAFE_F00D);
    rd(32'h100, r);
    chk("unmapped_above_ram", r, 32'h0);
    rd(MMIO + 32'h40, r);
    chk("unmapped_mmio", r, 32'h0);

    // Step 2: GPIO and cycle counter
    wr(A_GPIO, 32'h5A);
    chk("gpio_out", gpio_out, 32'h0000_005A);
    rd(A_GPIO, r);
    chk("gpio_rd", r, 32'h0000_005A);
    rd(A_CLO, c1);
    repeat (5) tick();
    rd(A_CLO, c2);
    chk("cycle_delta5", c2 - c1, 32'd5);
    rd(A_CHI, r);
    chk("cycle_hi", r, 32'h0);
    rd(A_STAT, r);
    chk("stat_idle", r, 32'h2);

    // Step 3: fill FIFO with no consumer, then overflow
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h41 + 32'(i));
    rd(A_STAT, r);
    chk("stat_full", r, 32'h1);
    chk("head_41", {24'b0, tx_data}, 32'h41);
    rd(A_TX, r);
    chk("con_tx_rd0", r, 32'h0);
    wr(A_TX, 32'h49);
    rd(A_STAT, r);
    chk("stat_full_ovf", r, 32'h5);

    // Step 4: drain, then clear overflow
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", {31'b0, tx_valid}, 32'h1);
      chk("drain_data", {24'b0, tx_data}, 32'h41 + 32'(i));
      tick();
    end
    chk("drain_done_valid", {31'b0, tx_valid}, 32'h0);
    rd(A_STAT, r);
    chk("stat_empty_ovf", r, 32'h6);
    wr(A_STAT, 32'h4);
    rd(A_STAT, r);
    chk("stat_cleared", r, 32'h2);

    // Step 5: push into full FIFO while popping
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h61 + 32'(i));
    rd(A_STAT, r);
    chk("stat_full2", r, 32'h1);
    tx_ready = 1'b1;
    wr(A_TX, 32'h50);
    rd(A_STAT, r);
    chk("stat_full_no_ovf", r, 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk("drain2_data", {24'b0, tx_data}, (i < 7) ? 32'h62 + 32'(i) : 32'h50);
      tick();
    end
    chk("drain2_done_valid", {31'b0, tx_valid}, 32'h0);
    rd(A_STAT, r);
    chk("stat_empty2", r, 32'h2);

    // Step 6: asynchronous reset in the middle of a drain
    tx_ready = 1'b0;
    wr(A_TX, 32'h70);
    wr(A_TX, 32'h71);
    tx_ready = 1'b1;
    tick();
    chk("pre_rst_head", {24'b0, tx_data}, 32'h71);
    ALUResultM = A_CLO;
    #1;
    reset = 1'b0;
    #1;
    chk("arst_txvalid", {31'b0, tx_valid}, 32'h0);
    chk("arst_txdata", {24'b0, tx_data}, 32'h0);
    chk("arst_gpio", gpio_out, 32'h0);
    chk("arst_cyclo", ReadDataM, 32'h0);
    rd(A_STAT, r);
    chk("arst_stat", r, 32'h2);
    rd(32'h10, r);
    chk("arst_ram_kept", r, 32'hDEAD_BEEF);
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    rd(A_CLO, r);
    chk("cycle_after_release", r, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
